// File: rtl/framebuffer_writer.sv
// Drawing-side writer for a double-buffered 1-bpp framebuffer.
// Clears the back buffer, plots handshaked points into it, then flips on the scan-out swap pulse.
module framebuffer_writer #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    localparam int unsigned ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS),
    localparam int unsigned X_WIDTH    = $clog2(HOR_ACTIVE_PIXELS),
    localparam int unsigned Y_WIDTH    = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pt_valid,
    output logic                  pt_ready,
    input  logic [X_WIDTH-1:0]    pt_x,
    input  logic [Y_WIDTH-1:0]    pt_y,
    input  logic                  frame_done,
    input  logic                  swap,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  write_data,
    output logic                  front_sel,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] H_STRIDE  = ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_DRAW      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic                  write_en_q, write_en_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic                  write_data_q, write_data_d;
    logic                  front_sel_q, front_sel_d;

    logic                  pt_in_range;
    logic [ADDR_WIDTH-1:0] pt_addr;

    // Operands widened to the full address width before the multiply so no row bits are lost.
    assign pt_in_range = (32'(pt_x) < HOR_ACTIVE_PIXELS) && (32'(pt_y) < VER_ACTIVE_PIXELS);
    assign pt_addr     = ADDR_WIDTH'(pt_y) * H_STRIDE + ADDR_WIDTH'(pt_x);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= 1'b0;
            front_sel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            front_sel_q  <= front_sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = 1'b0;
        front_sel_d  = front_sel_q;

        unique case (state_q)
            ST_CLEAR: begin
                write_en_d   = 1'b1;
                write_addr_d = clear_addr_q;
                if (clear_addr_q == LAST_ADDR) begin
                    clear_addr_d = '0;
                    state_d      = ST_DRAW;
                end else begin
                    clear_addr_d = clear_addr_q + 1'b1;
                end
            end
            ST_DRAW: begin
                // Out-of-range points still complete the handshake; only the write is suppressed.
                if (pt_valid && pt_in_range) begin
                    write_en_d   = 1'b1;
                    write_addr_d = pt_addr;
                    write_data_d = 1'b1;
                end
                if (frame_done) begin
                    state_d = ST_WAIT_SWAP;
                end
            end
            ST_WAIT_SWAP: begin
                if (swap) begin
                    front_sel_d = ~front_sel_q;
                    state_d     = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign pt_ready   = (state_q == ST_DRAW);
    assign busy       = (state_q != ST_DRAW);
    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign front_sel  = front_sel_q;

endmodule
